// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and default widths for the FIR accumulator
package fir_pkg;

    localparam int FIR_PROD_W = 16;
    localparam int FIR_ACC_W  = 21;
    localparam int FIR_TAPS   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } fir_acc_state_t;

endpackage

// File: rtl/fir_acc_add.sv
// rtl/fir_acc_add.sv - sign-extend, add, overflow detect; saturates when FIR_ACC_SAT_EN is defined
module fir_acc_add #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 21
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [IN_W-1:0]  i_data,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;

    // Replicate the product sign bit, add, and flag a same-sign add whose result sign flips
    always_comb begin
        w_ext = {{(ACC_W-IN_W){i_data[IN_W-1]}}, i_data};
        w_sum = i_acc + w_ext;
        o_ovf = (i_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != i_acc[ACC_W-1]);
`ifdef FIR_ACC_SAT_EN
        // Clamp toward the common operand sign
        if (o_ovf) begin
            o_sum = i_acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            o_sum = w_sum;
        end
`else
        o_sum = w_sum;
`endif
    end

endmodule

// File: rtl/fir_acc.sv
// rtl/fir_acc.sv - registered signed frame accumulator with valid/ready on both sides (option: FIR_ACC_SAT_EN)
module fir_acc
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_PROD_W,
    parameter int ACC_W = FIR_ACC_W,
    parameter int TAPS  = FIR_TAPS,
    localparam int CNT_W = $clog2(TAPS+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] tap_cnt,
    output logic             ovf,
    output logic             len_err
);

    localparam logic [CNT_W-1:0] TAPS_M1 = CNT_W'(TAPS - 1);

    fir_acc_state_t   r_state;
    fir_acc_state_t   w_next;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_len_err;
    logic             w_accept;
    logic             w_first;
    logic             w_cap;
    logic [ACC_W-1:0] w_acc_op;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;

    assign w_accept = in_valid && r_in_ready;
    assign w_first  = (r_state == IDLE);
    assign w_cap    = (r_state == ACC) && (r_cnt == TAPS_M1);
    // The first tap of a frame loads rather than adds, so the old sum never leaks in
    assign w_acc_op = w_first ? '0 : r_acc;

    fir_acc_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .i_acc  (w_acc_op),
        .i_data (in_data),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    // State register; ready is registered so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    // Next-state decode: frame closes on in_last or when the tap budget is used up
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = in_last ? DONE : ACC;
            ACC:  if (w_accept && (in_last || w_cap)) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode: result is presented for the whole DONE state
    always_comb begin
        out_valid      = (r_state == DONE);
        w_in_ready_nxt = (w_next != DONE);
    end

    // Accumulator, tap counter and sticky per-frame flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_len_err <= 1'b0;
        end else if (w_accept) begin
            r_acc     <= w_sum;
            r_cnt     <= w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
            r_ovf     <= (w_first ? 1'b0 : r_ovf) | w_ovf;
            r_len_err <= w_cap && !in_last;
        end else if ((r_state == DONE) && out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

    assign in_ready = r_in_ready;
    assign out_data = r_acc;
    assign tap_cnt  = r_cnt;
    assign ovf      = r_ovf;
    assign len_err  = r_len_err;

endmodule

// File: tb/tb_fir_acc.sv
// tb/tb_fir_acc.sv - directed self-checking bench for fir_acc
module tb_fir_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, in_ready17;
    logic [20:0] out_data;
    logic [16:0] out_data17;
    logic        out_valid, out_valid17;
    logic [5:0]  tap_cnt, tap_cnt17;
    logic        ovf, ovf17;
    logic        len_err, len_err17;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_acc dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .tap_cnt(tap_cnt),
        .ovf(ovf), .len_err(len_err)
    );

    fir_acc #(.ACC_W(17)) dut17 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready17), .out_data(out_data17),
        .out_valid(out_valid17), .out_ready(out_ready), .tap_cnt(tap_cnt17),
        .ovf(ovf17), .len_err(len_err17)
    );

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input logic [15:0] d, input logic last);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        tests++; if (out_data !== 21'd0)  begin fails++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tests++; if (tap_cnt !== 6'd0)    begin fails++; $display("FAIL rst_tap_cnt: got %0d want 0", tap_cnt); end
        tests++; if ({ovf, len_err} !== 2'b00) begin fails++; $display("FAIL rst_flags: got %b want 00", {ovf, len_err}); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        send(16'h0003, 1'b1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        tests++; if (out_data !== 21'd6) begin fails++; $display("FAIL basic_data: got %0d want 6", out_data); end
        tests++; if (tap_cnt !== 6'd3)   begin fails++; $display("FAIL basic_tap_cnt: got %0d want 3", tap_cnt); end
        tests++; if ({ovf, len_err} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b want 00", {ovf, len_err}); end
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL basic_done_ready: got %b want 0", in_ready); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_release: got %b want 0", out_valid); end
        tests++; if (tap_cnt !== 6'd0)   begin fails++; $display("FAIL basic_cnt_clear: got %0d want 0", tap_cnt); end
    endtask

    task automatic test_sign_ext();
        send(16'hFFFF, 1'b0);
        send(16'hFFFE, 1'b1);
        tests++; if (out_data !== 21'h1FFFFD) begin fails++; $display("FAIL sign_data: got %h want 1ffffd", out_data); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL sign_ovf: got %b want 0", ovf); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [16:0] exp17;
`ifdef FIR_ACC_SAT_EN
        exp17 = 17'h0FFFF;
`else
        exp17 = 17'h17FFD;
`endif
        send(16'h7FFF, 1'b0);
        send(16'h7FFF, 1'b0);
        tests++; if (ovf17 !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", ovf17); end
        send(16'h7FFF, 1'b1);
        tests++; if (out_data17 !== exp17) begin fails++; $display("FAIL ovf_data17: got %h want %h", out_data17, exp17); end
        tests++; if (ovf17 !== 1'b1) begin fails++; $display("FAIL ovf_flag17: got %b want 1", ovf17); end
        tests++; if (out_data !== 21'h017FFD) begin fails++; $display("FAIL ovf_data21: got %h want 017ffd", out_data); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_flag21: got %b want 0", ovf); end
        @(negedge clk);
    endtask

    task automatic test_len_err();
        for (int i = 0; i < 31; i++) send(16'h0001, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL len_early_valid: got %b want 0", out_valid); end
        tests++; if (tap_cnt !== 6'd31)  begin fails++; $display("FAIL len_cnt31: got %0d want 31", tap_cnt); end
        send(16'h0001, 1'b0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL len_valid: got %b want 1", out_valid); end
        tests++; if (out_data !== 21'd32) begin fails++; $display("FAIL len_data: got %0d want 32", out_data); end
        tests++; if (tap_cnt !== 6'd32)  begin fails++; $display("FAIL len_cnt: got %0d want 32", tap_cnt); end
        tests++; if (len_err !== 1'b1)   begin fails++; $display("FAIL len_err: got %b want 1", len_err); end
        tests++; if (ovf17 !== 1'b0)     begin fails++; $display("FAIL len_ovf_cleared: got %b want 0", ovf17); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(16'h0004, 1'b0);
        send(16'h0005, 1'b1);
        in_data = 16'h0007; in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
            tests++; if (out_data !== 21'd9) begin fails++; $display("FAIL hold_data[%0d]: got %0d want 9", i, out_data); end
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
            @(negedge clk);
        end
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL hold_len_err: got %b want 0", len_err); end
        out_ready = 1'b1;
        send(16'h0007, 1'b1);
        tests++; if (out_data !== 21'd7) begin fails++; $display("FAIL hold_next_data: got %0d want 7", out_data); end
        tests++; if (tap_cnt !== 6'd1)   begin fails++; $display("FAIL hold_next_cnt: got %0d want 1", tap_cnt); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        tests++; if (tap_cnt !== 6'd2) begin fails++; $display("FAIL mr_pre_cnt: got %0d want 2", tap_cnt); end
        rst_n = 1'b0;
        #1;
        tests++; if (tap_cnt !== 6'd0)   begin fails++; $display("FAIL mr_cnt: got %0d want 0", tap_cnt); end
        tests++; if (out_data !== 21'd0) begin fails++; $display("FAIL mr_data: got %0d want 0", out_data); end
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL mr_ready: got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mr_valid: got %b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'h0005, 1'b1);
        tests++; if (out_data !== 21'd5) begin fails++; $display("FAIL mr_new_data: got %0d want 5", out_data); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mr_new_valid: got %b want 1", out_valid); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_ext();
        test_overflow();
        test_len_err();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
